// File: rtl/receipt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | receipt_pkg: opcode constants, error codes, cost function, channel states   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package receipt_pkg;

  localparam logic [7:0] OP_REVEAL      = 8'h0F;
  localparam logic [7:0] OP_LAST_SIMPLE = 8'h10;
  localparam logic [7:0] OP_HALT        = 8'hFF;

  localparam logic [3:0] ERR_NONE           = 4'd0;
  localparam logic [3:0] ERR_MU_MISMATCH    = 4'd1;
  localparam logic [3:0] ERR_CHAIN_BREAK    = 4'd2;
  localparam logic [3:0] ERR_UNKNOWN_OPCODE = 4'd3;
  localparam logic [3:0] ERR_OVERFLOW       = 4'd4;
  localparam logic [3:0] ERR_LOCKED         = 4'd5;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_ARMED  = 2'd1,
    CH_LOCKED = 2'd2
  } chan_state_t;

  function automatic logic opcode_known(input logic [7:0] op);
    return (op <= OP_LAST_SIMPLE) || (op == OP_HALT);
  endfunction

  // REVEAL's (hi<<8)+lo never carries, so it is a plain concatenation.
  function automatic logic [15:0] opcode_cost(input logic [7:0] op,
                                              input logic [7:0] operand_hi,
                                              input logic [7:0] operand_lo);
    if (op == OP_REVEAL)
      return {operand_hi, operand_lo};
    else if (op <= OP_LAST_SIMPLE)
      return {8'h00, operand_lo};
    else
      return 16'h0000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/receipt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | receipt_fifo: synchronous FIFO, power-of-two depth, wrap-bit full/empty     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module receipt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                 (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/receipt_chain_verifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | receipt_chain_verifier: checks mu-cost receipts against per-channel chains  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module receipt_chain_verifier
  import receipt_pkg::*;
#(
  parameter  int MU_W  = 32,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 8,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_chan,
  input  logic [7:0]      in_opcode,
  input  logic [31:0]     in_operand,
  input  logic [MU_W-1:0] in_pre_mu,
  input  logic [MU_W-1:0] in_post_mu,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CW-1:0]   res_chan,
  output logic            res_ok,
  output logic [3:0]      res_err,
  output logic [MU_W-1:0] res_cost,
  input  logic [NCH-1:0]  chan_clear,
  output logic [NCH-1:0]  chan_locked,
  output logic [15:0]     pass_count,
  output logic [15:0]     fail_count
);

  localparam int c_ENTRY_W = CW + 24 + 2 * MU_W;

  logic                 r_in_en;
  logic                 w_push, w_pop, w_full, w_empty;
  logic [c_ENTRY_W-1:0] w_head;
  logic [CW-1:0]        w_chan;
  logic [7:0]           w_opcode, w_op_hi, w_op_lo;
  logic [MU_W-1:0]      w_pre_mu, w_post_mu, w_cost;
  logic [MU_W:0]        w_sum;
  logic [3:0]           w_err;
  chan_state_t          w_cur_state;
  chan_state_t          r_state     [NCH];
  chan_state_t          w_state_nxt [NCH];
  logic [MU_W-1:0]      r_expected  [NCH];
  logic [NCH-1:0]       w_load_exp;
  logic                 w_unused_operand;

  assign w_unused_operand = &{1'b0, in_operand[31:24], in_operand[15:8]};

  // in_ready is held low through reset and for the first edge after it.
  assign in_ready = r_in_en && !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && (!res_valid || res_ready);

  receipt_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({in_chan, in_opcode, in_operand[23:16], in_operand[7:0],
                 in_pre_mu, in_post_mu}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign {w_chan, w_opcode, w_op_hi, w_op_lo, w_pre_mu, w_post_mu} = w_head;

  assign w_cost      = MU_W'(opcode_cost(w_opcode, w_op_hi, w_op_lo));
  assign w_sum       = {1'b0, w_pre_mu} + {1'b0, w_cost};
  assign w_cur_state = r_state[w_chan];

  always_comb begin
    w_err = ERR_NONE;
    if (!opcode_known(w_opcode))
      w_err = ERR_UNKNOWN_OPCODE;
    else if (w_cur_state == CH_LOCKED)
      w_err = ERR_LOCKED;
    else if (w_sum[MU_W])
      w_err = ERR_OVERFLOW;
    else if (w_post_mu != w_sum[MU_W-1:0])
      w_err = ERR_MU_MISMATCH;
    else if ((w_cur_state == CH_ARMED) && (w_pre_mu != r_expected[w_chan]))
      w_err = ERR_CHAIN_BREAK;
  end

  // A clear always overrides the update from a coincident check.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_load_exp[i]  = 1'b0;
      if (chan_clear[i]) begin
        w_state_nxt[i] = CH_IDLE;
      end else if (w_pop && (w_chan == CW'(i))) begin
        if (w_err == ERR_NONE) begin
          w_state_nxt[i] = (w_opcode == OP_HALT) ? CH_IDLE : CH_ARMED;
          w_load_exp[i]  = (w_opcode != OP_HALT);
        end else if (w_err != ERR_LOCKED) begin
          w_state_nxt[i] = CH_LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i]    <= CH_IDLE;
        r_expected[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_load_exp[i]) r_expected[i] <= w_post_mu;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) chan_locked[i] = (r_state[i] == CH_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_en    <= 1'b0;
      res_valid  <= 1'b0;
      res_chan   <= '0;
      res_ok     <= 1'b0;
      res_err    <= '0;
      res_cost   <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      r_in_en <= 1'b1;
      if (w_pop) begin
        res_valid <= 1'b1;
        res_chan  <= w_chan;
        res_ok    <= (w_err == ERR_NONE);
        res_err   <= w_err;
        res_cost  <= w_cost;
        if (w_err == ERR_NONE) begin
          if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
        end else begin
          if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        end
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
